// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the unified memory port.
// slave: arbiter view; master: requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;
    logic          err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               busy, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data memory.
// Optional ARB_TIMEOUT_EN: abort an access after TIMEOUT cycles without mem_ready (err=1).
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_e;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    state_e        state_q;
    logic          gnt_dm_q;
    logic          last_dm_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          busy_q;
    logic          if_ack_q;
    logic          dm_ack_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          gnt_dm_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
`endif

    // DM wins when alone, or on a tie when IF was granted last
    assign gnt_dm_c = bus.dm_req & (~bus.if_req | ~last_dm_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_dm_q   <= 1'b0;
            last_dm_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.if_req | bus.dm_req) begin
                        gnt_dm_q  <= gnt_dm_c;
                        last_dm_q <= gnt_dm_c;
                        addr_q    <= gnt_dm_c ? bus.dm_addr : bus.if_addr;
                        wdata_q   <= gnt_dm_c ? bus.dm_wdata : '0;
                        mem_we_q  <= gnt_dm_c & bus.dm_we;
                        mem_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                        state_q   <= ACC;
                    end
                end
                ACC: begin
                    if (bus.mem_ready) begin
                        if (!mem_we_q) begin
                            if (gnt_dm_q) dm_rdata_q <= bus.mem_rdata;
                            else          if_rdata_q <= bus.mem_rdata;
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if_ack_q <= ~gnt_dm_q;
                        dm_ack_q <= gnt_dm_q;
                        state_q  <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Abort leaves both rdata registers untouched
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if_ack_q <= ~gnt_dm_q;
                        dm_ack_q <= gnt_dm_q;
                        err_q    <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum wait cycles for mem_ready (timeout build only).

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, synchronous, active-high reset.
- if_req, in, 1, instruction-fetch read request.
- if_addr, in, AW, fetch address.
- if_rdata, out, DW, fetch read data.
- if_ack, out, 1, fetch completion pulse.
- dm_req, in, 1, data-memory request.
- dm_we, in, 1, 1 = write, 0 = read.
- dm_addr, in, AW, data address.
- dm_wdata, in, DW, write data.
- dm_rdata, out, DW, data read data.
- dm_ack, out, 1, data completion pulse.
- mem_en, out, 1, unified memory access strobe.
- mem_we, out, 1, memory write enable.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data.
- mem_ready, in, 1, memory completes the current access this cycle.
- busy, out, 1, high in any state other than IDLE.
- err, out, 1, access aborted; valid with ack.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACC and RESP.
REQ-004 In IDLE with exactly one request high, the arbiter SHALL grant that requester and enter ACC next cycle.
REQ-005 In IDLE with both requests high, the arbiter SHALL grant the requester not granted last (round-robin via a last_grant register; last_grant resets to IF, so DM wins the first tie).
REQ-006 At grant, the arbiter SHALL latch address, write data, we (forced to 0 for IF) and the grantee; mem_addr, mem_wdata and mem_we SHALL come from these latches only.
REQ-007 In ACC, mem_en SHALL be 1; in IDLE and RESP, mem_en and mem_we SHALL be 0.
REQ-008 In ACC with mem_ready=1, the arbiter SHALL capture mem_rdata into the grantee's rdata register (reads only) and enter RESP.
REQ-009 In RESP, the grantee's ack SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-010 Minimum latency SHALL be: req at edge n, ACC in cycle n+1, mem_ready in cycle n+1, ack in cycle n+2.
REQ-011 Requesters SHALL hold req and operands stable until ack and drop req the cycle after ack; req is ignored in ACC and RESP.
REQ-012 Deasserting req during ACC SHALL NOT abort the access.
REQ-013 if_rdata and dm_rdata SHALL hold their last captured value until the next read completion for the same port; a write SHALL NOT alter dm_rdata.
REQ-014 if_ack and dm_ack SHALL never be high in the same cycle.

Reset
REQ-015 When rst=1 at a rising edge, the next state SHALL be IDLE with mem_en=0, mem_we=0, if_ack=0, dm_ack=0, busy=0, err=0, if_rdata=0, dm_rdata=0, last_grant=IF and timeout counter=0.
REQ-016 Reset asserted during ACC SHALL abandon the access with no ack issued.

Configuration
REQ-017 With ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entry to ACC and increment each ACC cycle without mem_ready.
- On reaching TIMEOUT, the arbiter SHALL enter RESP with ack=1 and err=1, and the rdata register SHALL be unchanged.
- mem_ready in the same cycle as the limit SHALL win, giving a normal completion with err=0.
REQ-018 Without ARB_TIMEOUT_EN, ACC SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-019 Bench SHALL cover these scenarios:
- if_req, if_addr=0x10, mem_ready same cycle as ACC, mem_rdata=0x8C220004 -> if_ack 2 cycles after req, if_rdata=0x8C220004.
- dm write: addr=0x40, wdata=0xCAFEF00D, mem_ready after 3 wait cycles -> mem_we=1 for 4 ACC cycles, dm_ack once, dm_rdata unchanged.
- Both requests every cycle from reset for 4 accesses -> grant order DM, IF, DM, IF; acks never coincide.
- rst asserted in 2nd ACC cycle -> next cycle IDLE, mem_en=0, no ack; a subsequent if_req is served normally.
- ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 -> ack with err=1 after 16 ACC cycles; with mem_ready on cycle 16 -> err=0.
